// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaled sawtooth/triangle counter, per-channel duty
// compare, double-buffered period/duty/mode committed only at period boundaries.
module pwm_multi_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             commit,
  input  logic [WIDTH-1:0] duty_in,
  input  logic [WIDTH-1:0] cnt,
  output logic             pwm
);
  logic [WIDTH-1:0] duty_shadow;
  logic [WIDTH-1:0] duty_active;

  // commit reads the pre-load shadow, so a load on a boundary stays pending
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_shadow <= '0;
      duty_active <= '0;
      pwm         <= 1'b0;
    end else begin
      if (load)   duty_shadow <= duty_in;
      if (commit) duty_active <= duty_shadow;
      pwm <= en && (duty_active > cnt);
    end
  end
endmodule

module pwm_multi #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [PRESCALE_W-1:0]     prescale,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty_flat,
  input  logic                      center_mode,
  input  logic                      load,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_start,
  output logic                      load_ack
);
  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;

  dir_t                              dir, dir_nxt;
  logic [PRESCALE_W-1:0]             pre_cnt;
  logic [WIDTH-1:0]                  cnt, cnt_nxt;
  logic [WIDTH-1:0]                  period_active, period_shadow;
  logic                              mode_active, mode_shadow, pending;
  logic                              tick, wrap, boundary, commit;
  logic [CHANNELS-1:0][WIDTH-1:0]    duty;

  assign duty     = duty_flat;
  assign tick     = en && (pre_cnt == prescale);
  assign boundary = wrap || !en;
  assign commit   = boundary && pending;

  always_ff @(posedge clk) begin
    if (rst)              pre_cnt <= '0;
    else if (!en || tick) pre_cnt <= '0;
    else                  pre_cnt <= pre_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir <= UP;
      cnt <= '0;
    end else begin
      dir <= dir_nxt;
      cnt <= cnt_nxt;
    end
  end

  // Triangle runs 0..P..1; P=1 has no down leg, so the top itself wraps.
  always_comb begin
    dir_nxt = dir;
    cnt_nxt = cnt;
    wrap    = 1'b0;
    if (!en) begin
      dir_nxt = UP;
      cnt_nxt = '0;
    end else if (tick) begin
      if (period_active == '0) begin
        dir_nxt = UP;
        cnt_nxt = '0;
        wrap    = 1'b1;
      end else if (!mode_active) begin
        dir_nxt = UP;
        if (cnt >= period_active) begin
          cnt_nxt = '0;
          wrap    = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end else begin
        case (dir)
          UP: begin
            if (cnt >= period_active) begin
              if (period_active == WIDTH'(1)) begin
                cnt_nxt = '0;
                wrap    = 1'b1;
              end else begin
                cnt_nxt = period_active - 1'b1;
                dir_nxt = DOWN;
              end
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
          DOWN: begin
            if (cnt <= WIDTH'(1)) begin
              cnt_nxt = '0;
              dir_nxt = UP;
              wrap    = 1'b1;
            end else begin
              cnt_nxt = cnt - 1'b1;
            end
          end
          default: begin
            cnt_nxt = '0;
            dir_nxt = UP;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      period_shadow <= '0;
      period_active <= '0;
      mode_shadow   <= 1'b0;
      mode_active   <= 1'b0;
      pending       <= 1'b0;
      period_start  <= 1'b0;
      load_ack      <= 1'b0;
    end else begin
      if (commit) begin
        period_active <= period_shadow;
        mode_active   <= mode_shadow;
      end
      if (load) begin
        period_shadow <= period;
        mode_shadow   <= center_mode;
      end
      pending      <= load || (pending && !commit);
      period_start <= wrap;
      load_ack     <= commit;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    pwm_multi_lane #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .load    (load),
      .commit  (commit),
      .duty_in (duty[i]),
      .cnt     (cnt),
      .pwm     (pwm_out[i])
    );
  end
endmodule
